// File: rtl/ampl_scheduler_if.sv
// Handshake and amplitude-store pins for ampl_scheduler.
// master = scheduler side, slave = router/neuron core/store side.
interface ampl_scheduler_if #(parameter int ADDR_W = 8);
  logic              ts_tick, clear_overrun;
  logic              in_valid, in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              out_req, out_ack;
  logic [ADDR_W-1:0] out_addr;
  logic              re, rd_valid;
  logic [ADDR_W-1:0] rd_addr, rd_neuron;
  logic              sp_in, sp_out;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy, sweep_done, overrun;

  modport master (
    input  ts_tick, clear_overrun, in_valid, in_addr, out_req, out_addr,
    output in_ready, out_ack, re, rd_valid, rd_addr, rd_neuron,
           sp_in, sp_out, wr_addr, busy, sweep_done, overrun
  );
  modport slave (
    output ts_tick, clear_overrun, in_valid, in_addr, out_req, out_addr,
    input  in_ready, out_ack, re, rd_valid, rd_addr, rd_neuron,
           sp_in, sp_out, wr_addr, busy, sweep_done, overrun
  );
endinterface

// File: rtl/ampl_scheduler.sv
// Amplitude RAM sequencer: per-timestep read sweep over all neurons plus a
// single-port write arbiter (output-spike clears vs queued input-spike loads).
module ampl_scheduler #(
  parameter int NEURON_NO  = 256,
  parameter int FIFO_DEPTH = 8,
  parameter int OUT_BURST  = 4
) (
  input  logic clk,
  input  logic reset,
  ampl_scheduler_if.master bus
);
  localparam int ADDR_W = $clog2(NEURON_NO);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BW     = $clog2(OUT_BURST + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NEURON_NO - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state;
  logic              re_q, rd_valid_q, sweep_done_q, overrun_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_neuron_q;

  // rd_addr_q doubles as the sweep counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      re_q         <= 1'b0;
      rd_addr_q    <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      case (state)
        IDLE: if (bus.ts_tick) begin
          state     <= SWEEP;
          re_q      <= 1'b1;
          rd_addr_q <= '0;
        end
        SWEEP: if (rd_addr_q == LAST) begin
          state        <= DONE;
          re_q         <= 1'b0;
          sweep_done_q <= 1'b1;
        end else begin
          rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q  <= 1'b0;
      rd_neuron_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rd_valid_q  <= re_q;
      rd_neuron_q <= rd_addr_q;
      if (bus.ts_tick && state != IDLE) overrun_q <= 1'b1;
      else if (bus.clear_overrun)       overrun_q <= 1'b0;
    end
  end

  // input-spike event FIFO
  logic [ADDR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wp, rp;
  logic [PTR_W:0]    count;
  logic [BW-1:0]     burst;
  logic              empty, full, force_in, grant_out, grant_in, push, in_ready;
  logic              sp_in_q, sp_out_q;
  logic [ADDR_W-1:0] wr_addr_q;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign force_in  = !empty && (burst == BW'(OUT_BURST));
  assign grant_out = bus.out_req && !force_in;
  assign grant_in  = !grant_out && !empty;
  // a pop in this cycle frees the slot, so a full FIFO can still accept
  assign in_ready  = !full || grant_in;
  assign push      = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.in_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      burst     <= '0;
      sp_in_q   <= 1'b0;
      sp_out_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      if (push)     wp <= wp + PTR_W'(1);
      if (grant_in) rp <= rp + PTR_W'(1);
      case ({push, grant_in})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (grant_in || empty) burst <= '0;
      else if (grant_out)    burst <= burst + BW'(1);
      sp_in_q  <= grant_in;
      sp_out_q <= grant_out;
      if (grant_out)     wr_addr_q <= bus.out_addr;
      else if (grant_in) wr_addr_q <= mem[rp];
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_ack    = grant_out;
  assign bus.re         = re_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_neuron  = rd_neuron_q;
  assign bus.sp_in      = sp_in_q;
  assign bus.sp_out     = sp_out_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.busy       = (state != IDLE);
  assign bus.sweep_done = sweep_done_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_ampl_scheduler.sv
// Directed bench for ampl_scheduler with NEURON_NO=8, FIFO_DEPTH=8, OUT_BURST=4.
module tb_ampl_scheduler;
  localparam int N = 8, DEPTH = 8, OB = 4, AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ampl_scheduler_if #(.ADDR_W(AW)) bus();
  ampl_scheduler #(.NEURON_NO(N), .FIFO_DEPTH(DEPTH), .OUT_BURST(OB)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.ts_tick = 0; bus.clear_overrun = 0; bus.in_valid = 0; bus.in_addr = '0;
    bus.out_req = 0; bus.out_addr = '0;
    #3;
    checks++;
    if ({bus.re, bus.rd_valid, bus.sp_in, bus.sp_out, bus.busy, bus.sweep_done, bus.overrun} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0", {bus.re, bus.rd_valid, bus.sp_in, bus.sp_out, bus.busy, bus.sweep_done, bus.overrun});
    end
    checks++;
    if ({bus.rd_addr, bus.rd_neuron, bus.wr_addr} !== 9'b0) begin
      errors++; $display("FAIL reset_addrs got %h exp 0", {bus.rd_addr, bus.rd_neuron, bus.wr_addr});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
    step; step;
    reset = 1'b1;
  endtask

  task automatic test_sweep;
    bus.ts_tick = 1; step; bus.ts_tick = 0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({bus.re, bus.busy, bus.sweep_done} !== 3'b110 || bus.rd_addr !== AW'(k)) begin
        errors++; $display("FAIL sweep_rd k=%0d got re/busy/done=%b addr=%0d exp 110 addr=%0d", k, {bus.re, bus.busy, bus.sweep_done}, bus.rd_addr, k);
      end
      checks++;
      if (bus.rd_valid !== (k != 0)) begin
        errors++; $display("FAIL sweep_rd_valid k=%0d got %b exp %b", k, bus.rd_valid, k != 0);
      end
      if (k != 0) begin
        checks++;
        if (bus.rd_neuron !== AW'(k - 1)) begin
          errors++; $display("FAIL sweep_rd_neuron k=%0d got %0d exp %0d", k, bus.rd_neuron, k - 1);
        end
      end
      step;
    end
    checks++;
    if ({bus.re, bus.rd_valid, bus.busy, bus.sweep_done} !== 4'b0111 || bus.rd_neuron !== AW'(N - 1)) begin
      errors++; $display("FAIL sweep_done_cycle got %b nrn=%0d exp 0111 nrn=%0d", {bus.re, bus.rd_valid, bus.busy, bus.sweep_done}, bus.rd_neuron, N - 1);
    end
    step;
    checks++;
    if ({bus.re, bus.rd_valid, bus.busy, bus.sweep_done} !== 4'b0000) begin
      errors++; $display("FAIL sweep_idle got %b exp 0000", {bus.re, bus.rd_valid, bus.busy, bus.sweep_done});
    end
  endtask

  task automatic test_overrun;
    bus.ts_tick = 1; step; bus.ts_tick = 0;
    step; step; step;
    bus.ts_tick = 1; step; bus.ts_tick = 0;
    checks++;
    if (bus.overrun !== 1'b1 || bus.re !== 1'b1 || bus.rd_addr !== AW'(4)) begin
      errors++; $display("FAIL overrun_set got ovr=%b re=%b addr=%0d exp 1 1 4", bus.overrun, bus.re, bus.rd_addr);
    end
    for (int k = 5; k < N; k++) begin
      step;
      checks++;
      if (bus.rd_addr !== AW'(k) || bus.re !== 1'b1) begin
        errors++; $display("FAIL overrun_sweep got addr=%0d re=%b exp %0d 1", bus.rd_addr, bus.re, k);
      end
    end
    step;
    checks++;
    if (bus.sweep_done !== 1'b1) begin
      errors++; $display("FAIL overrun_done got %b exp 1", bus.sweep_done);
    end
    step;
    bus.clear_overrun = 1; step; bus.clear_overrun = 0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear got %b exp 0", bus.overrun);
    end
    bus.ts_tick = 1; step;
    bus.clear_overrun = 1; step;
    bus.ts_tick = 0; bus.clear_overrun = 0;
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set_wins got %b exp 1", bus.overrun);
    end
    for (int i = 0; i < 20 && bus.busy; i++) step;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL overrun_wait_idle got busy=%b exp 0", bus.busy);
    end
    bus.clear_overrun = 1; step; bus.clear_overrun = 0;
  endtask

  task automatic test_fifo_in;
    bus.in_valid = 1; bus.in_addr = 3; step;
    checks++;
    if (bus.sp_in !== 1'b0) begin
      errors++; $display("FAIL fifo_no_bypass got sp_in=%b exp 0", bus.sp_in);
    end
    bus.in_addr = 5; step; bus.in_valid = 0;
    checks++;
    if ({bus.sp_in, bus.sp_out, bus.wr_addr} !== {2'b10, 3'd3}) begin
      errors++; $display("FAIL fifo_first got %b/%0d exp 10/3", {bus.sp_in, bus.sp_out}, bus.wr_addr);
    end
    step;
    checks++;
    if ({bus.sp_in, bus.sp_out, bus.wr_addr} !== {2'b10, 3'd5}) begin
      errors++; $display("FAIL fifo_second got %b/%0d exp 10/5", {bus.sp_in, bus.sp_out}, bus.wr_addr);
    end
    step;
    checks++;
    if ({bus.sp_in, bus.sp_out, bus.wr_addr, bus.in_ready} !== {2'b00, 3'd5, 1'b1}) begin
      errors++; $display("FAIL fifo_idle got %b/%0d rdy=%b exp 00/5 rdy=1", {bus.sp_in, bus.sp_out}, bus.wr_addr, bus.in_ready);
    end
  endtask

  task automatic test_burst;
    logic [AW-1:0] addrs [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0]    exp_ack = 8'b0010_1111;   // bit c = ack in cycle c
    logic [7:0]    exp_out = 8'b0010_1111;
    logic [7:0]    exp_in  = 8'b0001_0000;
    logic [AW-1:0] exp_wa  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5, 3'd5, 3'd5};
    int idx = 0;
    logic ack;
    bus.in_valid = 1; bus.in_addr = 7; step; bus.in_valid = 0;
    for (int c = 0; c < 8; c++) begin
      bus.out_req  = (idx < 5);
      bus.out_addr = addrs[idx < 5 ? idx : 4];
      #1;
      ack = bus.out_ack;
      checks++;
      if (ack !== exp_ack[c]) begin
        errors++; $display("FAIL burst_ack c=%0d got %b exp %b", c, ack, exp_ack[c]);
      end
      step;
      if (ack) idx++;
      checks++;
      if ({bus.sp_out, bus.sp_in, bus.wr_addr} !== {exp_out[c], exp_in[c], exp_wa[c]}) begin
        errors++; $display("FAIL burst_strobe c=%0d got out/in=%b%b addr=%0d exp %b%b addr=%0d", c, bus.sp_out, bus.sp_in, bus.wr_addr, exp_out[c], exp_in[c], exp_wa[c]);
      end
    end
    bus.out_req = 0;
  endtask

  task automatic test_full;
    logic [AW-1:0] drain [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd2};
    for (int k = 0; k <= 10; k++) begin
      bus.in_valid = 1; bus.in_addr = AW'(k % 8);
      bus.out_req = 1; bus.out_addr = 3'd6;
      #1;
      if (k == 9) begin
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_ack !== 1'b1) begin
          errors++; $display("FAIL full_in_ready got rdy=%b ack=%b exp 0 1", bus.in_ready, bus.out_ack);
        end
      end
      if (k == 10) begin
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_ack !== 1'b0) begin
          errors++; $display("FAIL full_push_pop got rdy=%b ack=%b exp 1 0", bus.in_ready, bus.out_ack);
        end
      end
      step;
    end
    bus.in_valid = 0; bus.out_req = 0;
    checks++;
    if ({bus.sp_in, bus.sp_out, bus.wr_addr} !== {2'b10, 3'd1}) begin
      errors++; $display("FAIL full_forced_pop got %b/%0d exp 10/1", {bus.sp_in, bus.sp_out}, bus.wr_addr);
    end
    for (int i = 0; i < 8; i++) begin
      step;
      checks++;
      if ({bus.sp_in, bus.sp_out, bus.wr_addr} !== {2'b10, drain[i]}) begin
        errors++; $display("FAIL full_drain i=%0d got %b/%0d exp 10/%0d", i, {bus.sp_in, bus.sp_out}, bus.wr_addr, drain[i]);
      end
    end
    step;
    checks++;
    if (bus.sp_in !== 1'b0) begin
      errors++; $display("FAIL full_drained got sp_in=%b exp 0", bus.sp_in);
    end
  endtask

  task automatic test_reset_mid;
    bus.ts_tick = 1; step; bus.ts_tick = 0;
    step; step;
    bus.in_valid = 1; bus.out_req = 1; bus.out_addr = 3'd6;
    for (int p = 0; p < 3; p++) begin
      bus.in_addr = AW'(p + 1); step;
    end
    bus.in_valid = 0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.re, bus.rd_valid, bus.sp_in, bus.sp_out, bus.busy, bus.sweep_done, bus.overrun} !== 7'b0 ||
        {bus.rd_addr, bus.rd_neuron, bus.wr_addr} !== 9'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid got %b %h rdy=%b exp 0 0 rdy=1", {bus.re, bus.rd_valid, bus.sp_in, bus.sp_out, bus.busy, bus.sweep_done, bus.overrun}, {bus.rd_addr, bus.rd_neuron, bus.wr_addr}, bus.in_ready);
    end
    bus.out_req = 0;
    step;
    reset = 1'b1; bus.ts_tick = 1; step; bus.ts_tick = 0;
    checks++;
    if (bus.re !== 1'b1 || bus.rd_addr !== 3'd0) begin
      errors++; $display("FAIL restart_sweep got re=%b addr=%0d exp 1 0", bus.re, bus.rd_addr);
    end
    for (int i = 0; i < 9; i++) begin
      step;
      checks++;
      if (bus.sp_in !== 1'b0 || bus.sp_out !== 1'b0) begin
        errors++; $display("FAIL reset_fifo_empty i=%0d got in/out=%b%b exp 00", i, bus.sp_in, bus.sp_out);
      end
    end
    for (int i = 0; i < 20 && bus.busy; i++) step;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL restart_wait_idle got busy=%b exp 0", bus.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_sweep;
    test_overrun;
    test_fifo_in;
    test_burst;
    test_full;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
